// File: rtl/car_parking_ctrl_if.sv
// Signal bundle between a parking-lot controller and its sensors/keypad/indicators.
// The master drives the sensor and keypad inputs; the controller is the slave.
interface car_parking_ctrl_if;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] pass1;
  logic [1:0] pass2;
  logic       gate_open;
  logic       green;
  logic       red;
  logic [3:0] count;
  logic       full;

  modport master (
    output entry_sensor, exit_sensor, pass1, pass2,
    input  gate_open, green, red, count, full
  );

  modport slave (
    input  entry_sensor, exit_sensor, pass1, pass2,
    output gate_open, green, red, count, full
  );
endinterface

// File: rtl/car_parking_ctrl.sv
// Car park barrier controller: admits cars on a two-digit code, lets cars out
// freely, and tracks occupancy up to CAPACITY. All outputs are registered.
module car_parking_ctrl #(
  parameter int         CAPACITY    = 8,
  parameter int         WAIT_CYCLES = 4,
  parameter logic [1:0] PASS1       = 2'b01,
  parameter logic [1:0] PASS2       = 2'b10
) (
  input  logic                clk,
  input  logic                rst,
  car_parking_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PASS  = 3'd1,
    RIGHT_PASS = 3'd2,
    WRONG_PASS = 3'd3,
    EXIT_PASS  = 3'd4
  } state_t;

  localparam logic [3:0] CAP_V      = 4'(CAPACITY);
  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       full_q, full_d;
  logic       gate_open_q, gate_open_d;
  logic       green_q, green_d;
  logic       red_q, red_d;
  logic       code_ok;

  assign code_ok = (bus.pass1 == PASS1) && (bus.pass2 == PASS2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      wait_cnt_q  <= 4'd0;
      full_q      <= 1'b0;
      gate_open_q <= 1'b0;
      green_q     <= 1'b0;
      red_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      full_q      <= full_d;
      gate_open_q <= gate_open_d;
      green_q     <= green_d;
      red_q       <= red_d;
    end
  end

  // Next state plus the occupancy and wait counters that move with it.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wait_cnt_d = 4'd0;
    unique case (state_q)
      IDLE: begin
        if (bus.exit_sensor && (count_q != 4'd0)) begin
          state_d = EXIT_PASS;
        end else if (bus.entry_sensor && !full_q) begin
          state_d = WAIT_PASS;
        end
      end
      WAIT_PASS: begin
        if (!bus.entry_sensor) begin
          state_d = IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = code_ok ? RIGHT_PASS : WRONG_PASS;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      WRONG_PASS: begin
        if (code_ok) begin
          state_d = RIGHT_PASS;
        end else if (!bus.entry_sensor) begin
          state_d = IDLE;
        end
      end
      RIGHT_PASS: begin
        if (!bus.entry_sensor) begin
          state_d = IDLE;
          if (count_q < CAP_V) begin
            count_d = count_q + 4'd1;
          end
        end
      end
      EXIT_PASS: begin
        if (!bus.exit_sensor) begin
          state_d = IDLE;
          if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they flip with the state flop.
  always_comb begin
    full_d      = (count_d == CAP_V);
    gate_open_d = (state_d == RIGHT_PASS) || (state_d == EXIT_PASS);
    green_d     = gate_open_d;
    red_d       = (state_d == WRONG_PASS) ||
                  ((state_d == IDLE) && full_d && bus.entry_sensor);
  end

  assign bus.gate_open = gate_open_q;
  assign bus.green     = green_q;
  assign bus.red       = red_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;

endmodule

// File: doc/car_parking_ctrl.md
CAR_PARKING_CTRL -- requirements
Module: car_parking_ctrl

Interface
REQ-001 Parameter CAPACITY, default 8, is the maximum number of cars held; legal range 1..15.
REQ-002 Parameter WAIT_CYCLES, default 4, is the number of clocks spent in WAIT_PASS before the code is checked; legal range 1..15.
REQ-003 Parameter PASS1, default 2'b01, is the first code digit.
REQ-004 Parameter PASS2, default 2'b10, is the second code digit.
REQ-005 clk  in  1  Single clock; all state updates on its rising edge.
REQ-006 rst  in  1  Reset, asynchronous and active-high.
REQ-007 entry_sensor  in  1  Car present at entrance; level, synchronous to clk.
REQ-008 exit_sensor  in  1  Car present at exit; level, synchronous to clk.
REQ-009 pass1  in  2  First code digit from keypad.
REQ-010 pass2  in  2  Second code digit from keypad.
REQ-011 gate_open  out  1  Barrier raised.
REQ-012 green  out  1  Admit indicator.
REQ-013 red  out  1  Reject/full indicator.
REQ-014 count  out  4  Cars currently inside.
REQ-015 full  out  1  High when count == CAPACITY.

Function
REQ-016 The FSM SHALL have five states: IDLE, WAIT_PASS, RIGHT_PASS, WRONG_PASS and EXIT_PASS.
REQ-017 All outputs SHALL be registered, and each output SHALL be a function of the current state only (Moore).
REQ-018 IDLE transitions:
  - exit_sensor=1 and count>0 -> EXIT_PASS.
  - else entry_sensor=1 and full=0 -> WAIT_PASS.
  - exit SHALL have priority when both sensors are high.
REQ-019 IDLE with entry_sensor=1 and full=1 SHALL remain in IDLE with red=1; exit_sensor=1 with count=0 SHALL be ignored.
REQ-020 WAIT_PASS SHALL load a wait counter with 0 on entry and increment it each clock.
REQ-021 When the wait counter reaches WAIT_CYCLES-1, WAIT_PASS SHALL go to RIGHT_PASS if pass1==PASS1 and pass2==PASS2, else to WRONG_PASS.
REQ-022 WAIT_PASS SHALL return to IDLE, with count unchanged, if entry_sensor falls before the check.
REQ-023 WRONG_PASS transitions: correct code -> RIGHT_PASS; entry_sensor=0 -> IDLE; otherwise stay.
REQ-024 RIGHT_PASS SHALL hold while entry_sensor=1; when entry_sensor=0 it SHALL go to IDLE and increment count by 1, saturating at CAPACITY.
REQ-025 EXIT_PASS SHALL hold while exit_sensor=1; when exit_sensor=0 it SHALL go to IDLE and decrement count by 1, saturating at 0.
REQ-026 Outputs by state:
  - gate_open=1 and green=1 in RIGHT_PASS and EXIT_PASS only.
  - red=1 in WRONG_PASS, and in IDLE when full and entry_sensor=1.
  - All three SHALL be 0 otherwise.
REQ-027 full SHALL update in the same cycle as count.
REQ-028 Sensor activity in the non-owning direction (e.g. exit_sensor while in RIGHT_PASS) SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force: state=IDLE, count=0, full=0, gate_open=0, green=0, red=0, wait counter=0.
REQ-030 Assertion of rst mid-operation (any state) SHALL abort the transaction with no count change; after rst falls, operation SHALL resume from IDLE on the next rising clk edge.

Verification
REQ-031 Reset, then entry_sensor=1 with pass1=01, pass2=10 -> WAIT_PASS for 4 clocks, then gate_open=green=1; drop entry_sensor -> count=1, gate_open=0.
REQ-032 Entry with pass1=11 -> red=1 after 4 clocks; change to 01/10 -> green=1 next cycle; entry_sensor=0 -> count increments.
REQ-033 Eight admitted cars -> count=8, full=1; ninth entry -> state stays IDLE, red=1, count stays 8.
REQ-034 count=3, entry_sensor and exit_sensor both raised together -> EXIT_PASS; exit_sensor=0 -> count=2.
REQ-035 count=0, exit_sensor=1 -> no gate_open, count=0.
REQ-036 rst asserted between clock edges during RIGHT_PASS -> gate_open=0 without waiting for an edge, count=0, state IDLE.
